bcd_conv_arbiter: RTL and testbench
===================================

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 req  input  3  per-requester level request (0 score, 1 timer, 2 level).
REQ-004 bin0, bin1, bin2  input  6 each  binary value of requester 0/1/2, range 0..63.
REQ-005 ack  output  3  one-hot, one-cycle pulse; the requester's bin was captured.
REQ-006 done  output  3  one-hot, one-cycle pulse; the requester's result register was updated.
REQ-007 bcd0, bcd1, bcd2  output  12 each  held BCD result per requester, {hundreds, tens, ones}.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 The block SHALL contain one shared shift-add-3 engine: 6-bit shift register plus three 4-bit digit registers.
REQ-010 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-011 IDLE: if any req bit is high, the block SHALL select one winner, load its bin into the shift register, clear the digits, set the shift count to 6, and go to SHIFT; otherwise it stays in IDLE.
REQ-012 ack[winner] SHALL be high during the first SHIFT cycle only.
REQ-013 SHIFT: each cycle, every digit >= 5 SHALL get +3, then {hundreds, tens, ones, shift reg} shifts left by one; count decrements; after the 6th shift go to DONE.
REQ-014 DONE: bcdN of the winner SHALL take the digit registers, done[winner] SHALL be high for that cycle, and the FSM returns to IDLE.
REQ-015 Other bcdN registers SHALL hold; bcdN changes only in a DONE cycle for channel N.
REQ-016 Latency: req sampled in IDLE at edge E -> ack high after E -> done high after E+7; one conversion per 8 cycles maximum.
REQ-017 Default arbitration SHALL be round-robin: search starts at last_grant+1 mod 3; last_grant updates in DONE.
REQ-018 bin inputs SHALL be sampled only at the IDLE->SHIFT edge; changes during SHIFT/DONE are ignored.
REQ-019 req is a level; a requester still high after its done is re-arbitrated normally, and requests arriving while busy wait, unlost.
REQ-020 A requester deasserting req before grant SHALL simply not be granted; no partial state.
REQ-021 Hundreds digit SHALL always be 0 for legal inputs; outputs span 12'h000..12'h063.
REQ-022 ack and done SHALL never be high in the same cycle, and each is at most one-hot.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, ack=0, done=0, busy=0, bcd0/1/2=12'h000, digits/shift/count=0, last_grant=2 (requester 0 wins first).
REQ-024 Reset mid-conversion SHALL abort without a done pulse or any bcdN update.

Configuration
REQ-025 Macro BCD_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (req[0] > req[1] > req[2]), and last_grant is unused. When undefined, round-robin per REQ-017 applies.

Verification
REQ-026 Reset, req=3'b001, bin0=59 -> ack=001 one cycle, 7 cycles later done=001, bcd0=12'h059, others 12'h000.
REQ-027 bin1=0, then bin1=63 on separate requests -> bcd1=12'h000, then 12'h063; hundreds is always 0.
REQ-028 req=3'b111 held, bins 10/20/30 (round-robin) -> done order 0,1,2,0 at 8-cycle spacing; bcd0=12'h010, bcd1=12'h020, bcd2=12'h030.
REQ-029 Same stimulus with BCD_ARB_FIXED_PRIO_EN -> requester 0 granted every conversion; done never shows 010 or 100.
REQ-030 bin0=45 granted, bin0 changed to 7 during SHIFT -> bcd0=12'h045.
REQ-031 rst_n pulsed low in the 3rd SHIFT cycle -> no done, bcdN=12'h000, busy=0; next req=3'b110 is granted to requester 1 first.

Source files
------------

// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle for bcd_conv_arbiter: three requesters share one
// binary-to-BCD engine; master drives requests and binaries, slave returns results.
interface bcd_conv_arbiter_if;
    logic [2:0]  req;
    logic [5:0]  bin0;
    logic [5:0]  bin1;
    logic [5:0]  bin2;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic [11:0] bcd0;
    logic [11:0] bcd1;
    logic [11:0] bcd2;
    logic        busy;

    modport master (
        output req, bin0, bin1, bin2,
        input  ack, done, bcd0, bcd1, bcd2, busy
    );

    modport slave (
        input  req, bin0, bin1, bin2,
        output ack, done, bcd0, bcd1, bcd2, busy
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Three-requester arbiter in front of one shared shift-add-3 (double dabble) engine.
// Define BCD_ARB_FIXED_PRIO_EN for fixed priority (0 > 1 > 2); default is round-robin.
module bcd_conv_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    bcd_conv_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [5:0]       sr_q, sr_d;
    logic [3:0]       hun_q, hun_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       one_q, one_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       win_q, win_d;
    logic [2:0]       ack_q, ack_d;
    logic [2:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0][11:0] bcd_q, bcd_d;
    logic [2:0][5:0]  bin_v;
    logic [1:0]       pick;

    assign bin_v = {bus.bin2, bus.bin1, bus.bin0};

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef BCD_ARB_FIXED_PRIO_EN
    always_comb begin
        if (bus.req[0])      pick = 2'd0;
        else if (bus.req[1]) pick = 2'd1;
        else                 pick = 2'd2;
    end
`else
    logic [1:0] last_q, last_d;

    // Search order starts one past the last requester that completed.
    always_comb begin
        case (last_q)
            2'd0:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        one_d   = one_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        ack_d   = 3'b000;
        done_d  = 3'b000;
        bcd_d   = bcd_q;
`ifndef BCD_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_d   = pick;
                    sr_d    = bin_v[pick];
                    hun_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                    cnt_d   = 3'd6;
                    ack_d   = 3'(3'b001 << pick);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust every digit before the shift so each stays a legal BCD digit.
                {hun_d, ten_d, one_d, sr_d} = {add3(hun_q), add3(ten_q), add3(one_q), sr_q} << 1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = DONE;
            end
            DONE: begin
                bcd_d[win_q] = {hun_q, ten_q, one_q};
                done_d       = 3'(3'b001 << win_q);
`ifndef BCD_ARB_FIXED_PRIO_EN
                last_d       = win_q;
`endif
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            hun_q   <= '0;
            ten_q   <= '0;
            one_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            bcd_q   <= '0;
`ifndef BCD_ARB_FIXED_PRIO_EN
            last_q  <= 2'd2;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
`ifndef BCD_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.ack  = ack_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.bcd0 = bcd_q[0];
    assign bus.bcd1 = bcd_q[1];
    assign bus.bcd2 = bcd_q[2];
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: literal vector table, corner sequences, and random
// traffic against a transaction-level model (arbitrate, wait 7 cycles, publish).
module tb_bcd_conv_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_conv_arbiter_if bus();

    bcd_conv_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: phase = cycles since grant, -1 when idle.
    int          m_phase;
    int          m_win;
    int          m_val;
    int          m_last;
    logic [2:0]  e_ack, e_done;
    logic        e_busy;
    logic [11:0] e_bcd [3];
    int          done_ch [$];
    int          done_cyc [$];

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int get_bin(input int i);
        case (i)
            0:       return int'(bus.bin0);
            1:       return int'(bus.bin1);
            default: return int'(bus.bin2);
        endcase
    endfunction

    function automatic int arb(input logic [2:0] r, input int last);
`ifdef BCD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = -1; m_win = 0; m_val = 0; m_last = 2;
        e_ack = 3'b000; e_done = 3'b000; e_busy = 1'b0;
        for (int i = 0; i < 3; i++) e_bcd[i] = 12'h000;
    endtask

    task automatic model_edge();
        e_ack  = 3'b000;
        e_done = 3'b000;
        if (m_phase < 0) begin
            if (|bus.req) begin
                m_win   = arb(bus.req, m_last);
                m_val   = get_bin(m_win);
                e_ack   = 3'(1 << m_win);
                m_phase = 0;
            end
        end else if (m_phase == 6) begin
            e_bcd[m_win] = to_bcd(m_val);
            e_done  = 3'(1 << m_win);
            m_last  = m_win;
            m_phase = -1;
        end else begin
            m_phase++;
        end
        e_busy = (m_phase >= 0);
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        check("ack",  12'(bus.ack),  12'(e_ack));
        check("done", 12'(bus.done), 12'(e_done));
        check("busy", 12'(bus.busy), 12'(e_busy));
        check("bcd0", bus.bcd0, e_bcd[0]);
        check("bcd1", bus.bcd1, e_bcd[1]);
        check("bcd2", bus.bcd2, e_bcd[2]);
    endtask

    // Inputs are set at the negedge; advance one clock and compare at the next negedge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
        for (int i = 0; i < 3; i++)
            if (bus.done[i]) begin done_ch.push_back(i); done_cyc.push_back(cyc); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  bin;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{3'b001, 6'd59, 12'h059};
        vt[1] = '{3'b010, 6'd0,  12'h000};
        vt[2] = '{3'b010, 6'd63, 12'h063};
        vt[3] = '{3'b100, 6'd7,  12'h007};
        vt[4] = '{3'b001, 6'd10, 12'h010};
        vt[5] = '{3'b100, 6'd45, 12'h045};
        vt[6] = '{3'b100, 6'd19, 12'h019};

        bus.req = 3'b000; bus.bin0 = '0; bus.bin1 = '0; bus.bin2 = '0;
        model_reset();
        #12;
        check_all();
        do_reset();

        // Single-requester conversions with literal expected results.
        for (int v = 0; v < 7; v++) begin
            bus.req = vt[v].req;
            bus.bin0 = vt[v].bin; bus.bin1 = vt[v].bin; bus.bin2 = vt[v].bin;
            step();
            check("tbl_ack", 12'(bus.ack), 12'(vt[v].req));
            bus.req = 3'b000;
            for (int c = 0; c < 7; c++) step();
            check("tbl_done", 12'(bus.done), 12'(vt[v].req));
            case (vt[v].req)
                3'b001:  check("tbl_bcd0", bus.bcd0, vt[v].exp_bcd);
                3'b010:  check("tbl_bcd1", bus.bcd1, vt[v].exp_bcd);
                default: check("tbl_bcd2", bus.bcd2, vt[v].exp_bcd);
            endcase
            check("tbl_hundreds", 12'(bus.bcd0[11:8] | bus.bcd1[11:8] | bus.bcd2[11:8]), 12'h0);
        end

        // All three requesting: order and spacing of completions.
        do_reset();
        done_ch.delete(); done_cyc.delete();
        bus.req = 3'b111; bus.bin0 = 6'd10; bus.bin1 = 6'd20; bus.bin2 = 6'd30;
        for (int c = 0; c < 32; c++) step();
        bus.req = 3'b000;
        check("rr_count", 12'(done_ch.size()), 12'd4);
        if (done_ch.size() == 4) begin
`ifdef BCD_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 4; i++) check("prio_order", 12'(done_ch[i]), 12'd0);
            check("prio_bcd0", bus.bcd0, 12'h010);
            check("prio_bcd1", bus.bcd1, 12'h000);
`else
            check("rr_order0", 12'(done_ch[0]), 12'd0);
            check("rr_order1", 12'(done_ch[1]), 12'd1);
            check("rr_order2", 12'(done_ch[2]), 12'd2);
            check("rr_order3", 12'(done_ch[3]), 12'd0);
            check("rr_bcd0", bus.bcd0, 12'h010);
            check("rr_bcd1", bus.bcd1, 12'h020);
            check("rr_bcd2", bus.bcd2, 12'h030);
`endif
            for (int i = 1; i < 4; i++) check("rr_spacing", 12'(done_cyc[i] - done_cyc[i-1]), 12'd8);
        end
        for (int c = 0; c < 8; c++) step();

        // bin changed during SHIFT must not affect the result.
        do_reset();
        bus.req = 3'b001; bus.bin0 = 6'd45;
        step();
        bus.req = 3'b000; bus.bin0 = 6'd7;
        for (int c = 0; c < 7; c++) step();
        check("hold_bcd0", bus.bcd0, 12'h045);

        // Reset in the third SHIFT cycle aborts; requester 1 wins next.
        bus.req = 3'b001; bus.bin0 = 6'd33;
        step();
        bus.req = 3'b000;
        step(); step();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("abort_busy", 12'(bus.busy), 12'h0);
        check("abort_bcd0", bus.bcd0, 12'h000);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step();
        bus.req = 3'b110; bus.bin1 = 6'd21; bus.bin2 = 6'd52;
        step();
        check("post_reset_ack", 12'(bus.ack), 12'h002);
        bus.req = 3'b000;
        for (int c = 0; c < 8; c++) step();
        check("post_reset_bcd1", bus.bcd1, 12'h021);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
            bus.bin0 = 6'($urandom_range(0, 63));
            bus.bin1 = 6'($urandom_range(0, 63));
            bus.bin2 = 6'($urandom_range(0, 63));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
